// File: rtl/hot_addr_collector.sv
// Collects hot addresses from the tracker into a circular buffer and pops them to the migration side.
// The query/drain epoch FSM runs independently; the address port is accepted in every state.
module hot_addr_collector #(
    parameter int ADDR_SIZE  = 33,
    parameter int DEPTH      = 64,
    parameter int DRAIN_IDLE = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     csr_enable,
    input  logic [31:0]              csr_epoch_cycles,
    output logic                     query_en,
    input  logic                     query_ready,
    input  logic                     mig_addr_en,
    input  logic [ADDR_SIZE-1:0]     mig_addr,
    output logic                     mig_addr_ready,
    output logic                     pop_valid,
    output logic [ADDR_SIZE-1:0]     pop_addr,
    input  logic                     pop_ready,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              epoch_cnt,
    output logic [15:0]              drop_cnt
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int IDLE_W = $clog2(DRAIN_IDLE) + 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_IDLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_QUERY,
        S_DRAIN
    } state_t;

    state_t              state, state_nxt;
    logic [31:0]         timer, timer_nxt;
    logic [IDLE_W-1:0]   idle_cnt, idle_nxt;
    logic                epoch_inc;
    logic [31:0]         reload_val;

    // An epoch length of 0 behaves like 1.
    assign reload_val = (csr_epoch_cycles == 32'd0) ? 32'd0 : csr_epoch_cycles - 32'd1;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        idle_nxt  = idle_cnt;
        epoch_inc = 1'b0;
        case (state)
            S_IDLE: begin
                if (csr_enable) begin
                    state_nxt = S_WAIT;
                    timer_nxt = reload_val;
                end
            end
            S_WAIT: begin
                if (!csr_enable) begin
                    state_nxt = S_IDLE;
                end else if (timer == 32'd0) begin
                    state_nxt = S_QUERY;
                end else begin
                    timer_nxt = timer - 32'd1;
                end
            end
            S_QUERY: begin
                if (query_ready) begin
                    state_nxt = S_DRAIN;
                    idle_nxt  = '0;
                end
            end
            S_DRAIN: begin
                if (mig_addr_en) begin
                    idle_nxt = '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    epoch_inc = 1'b1;
                    if (csr_enable) begin
                        state_nxt = S_WAIT;
                        timer_nxt = reload_val;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    idle_nxt = idle_cnt + IDLE_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            timer          <= '0;
            idle_cnt       <= '0;
            query_en       <= 1'b0;
            epoch_cnt      <= '0;
            mig_addr_ready <= 1'b0;
        end else begin
            state          <= state_nxt;
            timer          <= timer_nxt;
            idle_cnt       <= idle_nxt;
            query_en       <= (state_nxt == S_QUERY);
            epoch_cnt      <= epoch_cnt + {31'd0, epoch_inc};
            mig_addr_ready <= 1'b1;
        end
    end

    // Handshakes: a transfer happens on a cycle where valid (en) and ready are both 1;
    // valid is held with stable data until then. pop_ready with pop_valid=0 is ignored.
    logic [ADDR_SIZE-1:0] mem [DEPTH];
    logic [PTR_W:0]       wr_ptr, rd_ptr, rd_ptr_nxt;
    logic                 full, accept, do_write, do_drop, do_pop;
    logic [ADDR_SIZE-1:0] head_nxt;

    assign full     = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
    assign accept   = mig_addr_en & mig_addr_ready;
    assign do_write = accept & ~full;
    assign do_drop  = accept & full;
    assign pop_valid = (occupancy != '0);
    assign do_pop   = pop_valid & pop_ready;
    assign rd_ptr_nxt = rd_ptr + {{PTR_W{1'b0}}, do_pop};

    // A write into the slot that is about to become head bypasses the array.
    assign head_nxt = (do_write && (wr_ptr[PTR_W-1:0] == rd_ptr_nxt[PTR_W-1:0]))
                      ? mig_addr : mem[rd_ptr_nxt[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr[PTR_W-1:0]] <= mig_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            pop_addr  <= '0;
            drop_cnt  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + {{PTR_W{1'b0}}, 1'b1};
            end
            rd_ptr <= rd_ptr_nxt;
            if (do_write || do_pop) begin
                pop_addr <= head_nxt;
            end
            case ({do_write, do_pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
            if (do_drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hot_addr_collector.sv
// Directed bench for hot_addr_collector: epoch timing, query handshake, buffer order,
// overflow drops, simultaneous push/pop, async reset and zero-length epochs.
module tb_hot_addr_collector;

    localparam int ADDR_SIZE  = 33;
    localparam int DEPTH      = 64;
    localparam int DRAIN_IDLE = 16;
    localparam int OCC_W      = $clog2(DEPTH) + 1;

    logic                 clk;
    logic                 rst;
    logic                 csr_enable;
    logic [31:0]          csr_epoch_cycles;
    logic                 query_en;
    logic                 query_ready;
    logic                 mig_addr_en;
    logic [ADDR_SIZE-1:0] mig_addr;
    logic                 mig_addr_ready;
    logic                 pop_valid;
    logic [ADDR_SIZE-1:0] pop_addr;
    logic                 pop_ready;
    logic [OCC_W-1:0]     occupancy;
    logic [31:0]          epoch_cnt;
    logic [15:0]          drop_cnt;

    hot_addr_collector #(
        .ADDR_SIZE (ADDR_SIZE),
        .DEPTH     (DEPTH),
        .DRAIN_IDLE(DRAIN_IDLE)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .csr_enable      (csr_enable),
        .csr_epoch_cycles(csr_epoch_cycles),
        .query_en        (query_en),
        .query_ready     (query_ready),
        .mig_addr_en     (mig_addr_en),
        .mig_addr        (mig_addr),
        .mig_addr_ready  (mig_addr_ready),
        .pop_valid       (pop_valid),
        .pop_addr        (pop_addr),
        .pop_ready       (pop_ready),
        .occupancy       (occupancy),
        .epoch_cnt       (epoch_cnt),
        .drop_cnt        (drop_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // scoreboard
    int checks = 0;
    int errors = 0;
    logic [ADDR_SIZE-1:0] exp_q[$];
    int model_occ  = 0;
    int model_drop = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ADDR_SIZE-1:0] rand_addr();
        logic [ADDR_SIZE-1:0] a;
        a = {($urandom_range(0, 1) != 0), 32'($urandom())};
        return a;
    endfunction

    // driver tasks
    task automatic push(input logic [ADDR_SIZE-1:0] a);
        mig_addr_en = 1'b1;
        mig_addr    = a;
        if (model_occ < DEPTH) begin
            exp_q.push_back(a);
            model_occ++;
        end else if (model_drop < 16'hFFFF) begin
            model_drop++;
        end
        step();
        mig_addr_en = 1'b0;
    endtask

    task automatic pop_one(input string tag);
        check({tag, "_valid"}, pop_valid, 1);
        if (exp_q.size() != 0) begin
            check({tag, "_addr"}, pop_addr, exp_q[0]);
            void'(exp_q.pop_front());
            model_occ--;
        end
        pop_ready = 1'b1;
        step();
        pop_ready = 1'b0;
    endtask

    task automatic push_pop(input string tag, input logic [ADDR_SIZE-1:0] a);
        bit was_full;
        was_full = (model_occ == DEPTH);
        if (exp_q.size() != 0) begin
            check({tag, "_head"}, pop_addr, exp_q[0]);
            void'(exp_q.pop_front());
            model_occ--;
        end
        if (!was_full) begin
            exp_q.push_back(a);
            model_occ++;
        end else if (model_drop < 16'hFFFF) begin
            model_drop++;
        end
        mig_addr_en = 1'b1;
        mig_addr    = a;
        pop_ready   = 1'b1;
        step();
        mig_addr_en = 1'b0;
        pop_ready   = 1'b0;
    endtask

    task automatic wait_query(input int max_cycles, output int cyc);
        cyc = -1;
        for (int i = 0; i < max_cycles; i++) begin
            if (query_en) begin
                cyc = i;
                break;
            end
            step();
        end
    endtask

    initial begin
        int first_q, second_q, n_high, cyc;
        rst = 1'b1;
        csr_enable = 1'b0;
        csr_epoch_cycles = 32'd0;
        query_ready = 1'b0;
        mig_addr_en = 1'b0;
        mig_addr = '0;
        pop_ready = 1'b0;
        step();
        step();
        check("rst_query_en", query_en, 0);
        check("rst_mig_ready", mig_addr_ready, 0);
        check("rst_pop_valid", pop_valid, 0);
        check("rst_pop_addr", pop_addr, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_epoch_cnt", epoch_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        rst = 1'b0;
        step();
        check("mig_ready_after_rst", mig_addr_ready, 1);

        // periodic epochs, 10-cycle epoch, tracker always ready
        csr_epoch_cycles = 32'd10;
        query_ready = 1'b1;
        csr_enable = 1'b1;
        first_q = -1;
        second_q = -1;
        n_high = 0;
        for (int k = 0; k < 45; k++) begin
            step();
            if (query_en) begin
                n_high++;
                if (first_q < 0) first_q = k;
                else if (second_q < 0) second_q = k;
            end
            if (k == 30) check("t1_epoch_after_first", epoch_cnt, 1);
        end
        check("t1_first_query", 64'(first_q), 64'(10));
        check("t1_second_query", 64'(second_q), 64'(37));
        check("t1_query_pulses", 64'(n_high), 64'(2));
        csr_enable = 1'b0;
        n_high = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (query_en) n_high++;
        end
        check("t1_idle_no_query", 64'(n_high), 64'(0));
        check("t1_epoch_after_disable", epoch_cnt, 2);

        // query held off by the tracker
        csr_epoch_cycles = 32'd3;
        query_ready = 1'b0;
        csr_enable = 1'b1;
        wait_query(20, cyc);
        check("t2_query_seen", (cyc >= 0), 1);
        for (int k = 0; k < 5; k++) begin
            step();
            check("t2_query_held", query_en, 1);
        end
        query_ready = 1'b1;
        csr_enable = 1'b0;
        step();
        check("t2_query_drop", query_en, 0);
        query_ready = 1'b0;

        // ordered drain of three boundary addresses
        push(33'h1_0000_0000);
        push(33'h0_0000_0055);
        push(33'h1_FFFF_FFFF);
        check("t3_occ3", occupancy, 3);
        pop_one("t3_pop0");
        check("t3_occ2", occupancy, 2);
        pop_one("t3_pop1");
        check("t3_occ1", occupancy, 1);
        pop_one("t3_pop2");
        check("t3_occ0", occupancy, 0);
        check("t3_empty", pop_valid, 0);
        pop_ready = 1'b1;
        step();
        pop_ready = 1'b0;
        check("t3_pop_empty_occ", occupancy, 0);
        for (int k = 0; k < 20; k++) step();
        check("t3_epoch", epoch_cnt, 3);

        // overflow and simultaneous push/pop
        for (int i = 0; i < DEPTH; i++) push(rand_addr());
        check("t4_full_occ", occupancy, 64'(model_occ));
        for (int i = 0; i < 5; i++) push(rand_addr());
        check("t4_full_occ2", occupancy, 64'(DEPTH));
        check("t4_drop5", drop_cnt, 64'(model_drop));
        check("t4_ready_full", mig_addr_ready, 1);
        push_pop("t4_pp_full", rand_addr());
        check("t4_pp_full_drop", drop_cnt, 64'(model_drop));
        check("t4_pp_full_occ", occupancy, 64'(DEPTH - 1));
        while (model_occ > 10) pop_one("t4_pop");
        check("t4_occ10", occupancy, 10);
        push_pop("t4_pp10", rand_addr());
        check("t4_pp10_occ", occupancy, 10);
        while (model_occ > 0) pop_one("t4_pop_tail");
        check("t4_final_occ", occupancy, 0);
        check("t4_final_valid", pop_valid, 0);
        check("t4_final_drop", drop_cnt, 6);

        // reset in the middle of a drain
        csr_epoch_cycles = 32'd2;
        query_ready = 1'b1;
        csr_enable = 1'b1;
        wait_query(20, cyc);
        check("t5_query_seen", (cyc >= 0), 1);
        step();
        csr_enable = 1'b0;
        for (int i = 0; i < 7; i++) push(rand_addr());
        check("t5_occ7", occupancy, 7);
        rst = 1'b1;
        #1;
        check("t5_rst_query_en", query_en, 0);
        check("t5_rst_occ", occupancy, 0);
        check("t5_rst_valid", pop_valid, 0);
        check("t5_rst_pop_addr", pop_addr, 0);
        check("t5_rst_epoch", epoch_cnt, 0);
        check("t5_rst_drop", drop_cnt, 0);
        check("t5_rst_ready", mig_addr_ready, 0);
        exp_q.delete();
        model_occ = 0;
        model_drop = 0;
        step();
        step();
        rst = 1'b0;
        n_high = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (query_en) n_high++;
        end
        check("t5_idle_no_query", 64'(n_high), 64'(0));
        check("t5_idle_epoch", epoch_cnt, 0);
        check("t5_idle_ready", mig_addr_ready, 1);

        // zero epoch length behaves as one cycle
        csr_epoch_cycles = 32'd0;
        csr_enable = 1'b1;
        first_q = -1;
        second_q = -1;
        for (int k = 0; k < 25; k++) begin
            step();
            if (query_en) begin
                if (first_q < 0) first_q = k;
                else if (second_q < 0) second_q = k;
            end
        end
        check("t6_first_query", 64'(first_q), 64'(1));
        check("t6_second_query", 64'(second_q), 64'(19));
        check("t6_epoch", epoch_cnt, 1);
        csr_enable = 1'b0;

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
